ram_mp_pipe: RTL and testbench

- Parametrised successor to the dual-port read-first RAM: NUM_PORTS symmetric read/write ports on one clock.
- Adds selectable write mode, a configurable 1–3 stage read pipeline with per-port stall, and a per-port valid/address tag that travels with the data.
- Adds deterministic multi-port write-collision resolution.
- Sits between the core's load/store and fetch paths and on-chip BRAM.

---
 rtl/ram_mp_pipe.sv | 159 +++++++++++++++
 tb/tb_ram_mp_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_mp_pipe.sv
// Multi-port byte-writable RAM with a per-port stallable read pipeline carrying valid/address tags.
// Define QU_RAM_COLLISION_FLAG_EN to add the per-port collision output. The array is never touched by rst.
module ram_mp_pipe #(
  parameter int NUM_PORTS    = 2,
  parameter int NB_COL       = 4,
  parameter int COL_WIDTH    = 8,
  parameter int RAM_DEPTH    = 1024,
  parameter int READ_LATENCY = 2,
  parameter     WRITE_MODE   = "READ_FIRST",
  parameter     INIT_FILE    = "",
  localparam int ADDR_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1,
  localparam int DW     = NB_COL * COL_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          en,
  input  logic [NUM_PORTS*NB_COL-1:0]   we,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
  input  logic [NUM_PORTS*DW-1:0]       din,
  input  logic [NUM_PORTS-1:0]          regce,
  output logic [NUM_PORTS*DW-1:0]       dout,
  output logic [NUM_PORTS-1:0]          valid,
  output logic [NUM_PORTS*ADDR_W-1:0]   valid_addr
`ifdef QU_RAM_COLLISION_FLAG_EN
  ,
  output logic [NUM_PORTS-1:0]          collision
`endif
);

  localparam bit MODE_WF = (WRITE_MODE == "WRITE_FIRST");
  localparam bit MODE_NC = (WRITE_MODE == "NO_CHANGE");

  logic [DW-1:0]     mem [RAM_DEPTH];

  logic [ADDR_W-1:0] a       [NUM_PORTS];
  logic [DW-1:0]     d       [NUM_PORTS];
  logic [NB_COL-1:0] we_raw  [NUM_PORTS];
  logic [NB_COL-1:0] w       [NUM_PORTS];
  logic              inr     [NUM_PORTS];
  logic [DW-1:0]     rd      [NUM_PORTS];

  logic [DW-1:0]     s1_data_d  [NUM_PORTS];
  logic              s1_valid_d [NUM_PORTS];
  logic [ADDR_W-1:0] s1_addr_d  [NUM_PORTS];

  logic [DW-1:0]     data_q  [NUM_PORTS][READ_LATENCY];
  logic              valid_q [NUM_PORTS][READ_LATENCY];
  logic [ADDR_W-1:0] addr_q  [NUM_PORTS][READ_LATENCY];

  // Port unpacking; w is the effective write mask (enabled and in range).
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      a[p]      = addr[p*ADDR_W +: ADDR_W];
      d[p]      = din[p*DW +: DW];
      we_raw[p] = we[p*NB_COL +: NB_COL];
      inr[p]    = ({1'b0, a[p]} < (ADDR_W+1)'(RAM_DEPTH));
      w[p]      = (en[p] && inr[p]) ? we_raw[p] : '0;
      rd[p]     = inr[p] ? mem[a[p]] : '0;
      if (MODE_WF) begin
        for (int i = 0; i < NB_COL; i++)
          if (w[p][i]) rd[p][i*COL_WIDTH +: COL_WIDTH] = d[p][i*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  // Stage-1 capture: bubble when idle, hold-and-invalidate for NO_CHANGE writes.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      s1_data_d[p]  = '0;
      s1_valid_d[p] = 1'b0;
      s1_addr_d[p]  = '0;
      if (en[p]) begin
        if (MODE_NC && (|we_raw[p])) begin
          s1_data_d[p] = data_q[p][0];
        end else begin
          s1_data_d[p]  = rd[p];
          s1_valid_d[p] = 1'b1;
          s1_addr_d[p]  = a[p];
        end
      end
    end
  end

  // Later ports are assigned last, so the highest index wins each contested byte.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++)
      for (int i = 0; i < NB_COL; i++)
        if (w[p][i]) mem[a[p]][i*COL_WIDTH +: COL_WIDTH] <= d[p][i*COL_WIDTH +: COL_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++)
        for (int s = 0; s < READ_LATENCY; s++) begin
          data_q[p][s]  <= '0;
          valid_q[p][s] <= 1'b0;
          addr_q[p][s]  <= '0;
        end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (regce[p]) begin
          data_q[p][0]  <= s1_data_d[p];
          valid_q[p][0] <= s1_valid_d[p];
          addr_q[p][0]  <= s1_addr_d[p];
          for (int s = 1; s < READ_LATENCY; s++) begin
            data_q[p][s]  <= data_q[p][s-1];
            valid_q[p][s] <= valid_q[p][s-1];
            addr_q[p][s]  <= addr_q[p][s-1];
          end
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      dout[p*DW +: DW]           = data_q[p][READ_LATENCY-1];
      valid[p]                   = valid_q[p][READ_LATENCY-1];
      valid_addr[p*ADDR_W +: ADDR_W] = addr_q[p][READ_LATENCY-1];
    end
  end

`ifdef QU_RAM_COLLISION_FLAG_EN
  logic col_d [NUM_PORTS];
  logic col_q [NUM_PORTS][READ_LATENCY];

  // A write loses to a higher port on any shared byte; a pure read collides with any other writer.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      col_d[p] = 1'b0;
      for (int q = 0; q < NUM_PORTS; q++) begin
        if (q != p && en[p] && en[q] && inr[p] && a[q] == a[p]) begin
          if (q > p && (|(w[q] & w[p]))) col_d[p] = 1'b1;
          if (!(|we_raw[p]) && (|w[q]))  col_d[p] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++)
        for (int s = 0; s < READ_LATENCY; s++) col_q[p][s] <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (regce[p]) begin
          col_q[p][0] <= col_d[p];
          for (int s = 1; s < READ_LATENCY; s++) col_q[p][s] <= col_q[p][s-1];
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) collision[p] = col_q[p][READ_LATENCY-1];
  end
`endif

endmodule

// File: tb/tb_ram_mp_pipe.sv
// Directed bench: a 2-port READ_FIRST/latency-2 RAM plus 4-port WRITE_FIRST/latency-3 and
// NO_CHANGE/latency-1 (depth 1000) RAMs sharing one stimulus bus.
module tb_ram_mp_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]   a_en, a_regce, a_valid;
  logic [7:0]   a_we;
  logic [19:0]  a_addr, a_vaddr;
  logic [63:0]  a_din, a_dout;

  logic [3:0]   b_en, b_regce, b_valid, c_valid;
  logic [15:0]  b_we;
  logic [39:0]  b_addr, b_vaddr, c_vaddr;
  logic [127:0] b_din, b_dout, c_dout;
`ifdef QU_RAM_COLLISION_FLAG_EN
  logic [1:0]   a_col;
  logic [3:0]   b_col, c_col;
`endif

  ram_mp_pipe #(.NUM_PORTS(2), .READ_LATENCY(2), .WRITE_MODE("READ_FIRST")) u_a (
    .clk(clk), .rst(rst), .en(a_en), .we(a_we), .addr(a_addr), .din(a_din), .regce(a_regce),
    .dout(a_dout), .valid(a_valid), .valid_addr(a_vaddr)
`ifdef QU_RAM_COLLISION_FLAG_EN
    , .collision(a_col)
`endif
  );

  ram_mp_pipe #(.NUM_PORTS(4), .READ_LATENCY(3), .WRITE_MODE("WRITE_FIRST")) u_b (
    .clk(clk), .rst(rst), .en(b_en), .we(b_we), .addr(b_addr), .din(b_din), .regce(b_regce),
    .dout(b_dout), .valid(b_valid), .valid_addr(b_vaddr)
`ifdef QU_RAM_COLLISION_FLAG_EN
    , .collision(b_col)
`endif
  );

  ram_mp_pipe #(.NUM_PORTS(4), .READ_LATENCY(1), .WRITE_MODE("NO_CHANGE"), .RAM_DEPTH(1000)) u_c (
    .clk(clk), .rst(rst), .en(b_en), .we(b_we), .addr(b_addr), .din(b_din), .regce(b_regce),
    .dout(c_dout), .valid(c_valid), .valid_addr(c_vaddr)
`ifdef QU_RAM_COLLISION_FLAG_EN
    , .collision(c_col)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [127:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic a_idle();
    a_en = '0; a_we = '0; a_addr = '0; a_din = '0;
  endtask

  task automatic a_drive(input int p, input logic [3:0] we, input logic [9:0] ad, input logic [31:0] dv);
    a_en[p] = 1'b1; a_we[p*4 +: 4] = we; a_addr[p*10 +: 10] = ad; a_din[p*32 +: 32] = dv;
  endtask

  task automatic a_access(input int p, input logic [3:0] we, input logic [9:0] ad, input logic [31:0] dv);
    a_idle(); a_drive(p, we, ad, dv); tick(); a_idle();
  endtask

  task automatic b_idle();
    b_en = '0; b_we = '0; b_addr = '0; b_din = '0;
  endtask

  task automatic b_drive(input int p, input logic [3:0] we, input logic [9:0] ad, input logic [31:0] dv);
    b_en[p] = 1'b1; b_we[p*4 +: 4] = we; b_addr[p*10 +: 10] = ad; b_din[p*32 +: 32] = dv;
  endtask

  task automatic b_access(input int p, input logic [3:0] we, input logic [9:0] ad, input logic [31:0] dv);
    b_idle(); b_drive(p, we, ad, dv); tick(); b_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] e;
    logic [9:0]   ad;
    rst = 1'b1; a_idle(); a_regce = '1; b_idle(); b_regce = '1;
    tick(2);
    check("rst_a_valid", a_valid, 0);
    check("rst_a_dout", a_dout, 0);
    check("rst_b_vaddr", b_vaddr, 0);
    check("rst_c_valid", c_valid, 0);
    rst = 1'b0;
    tick();

    // port0 writes, port1 reads next cycle: result two edges after the write
    a_access(0, 4'hF, 10'd5, 32'hDEADBEEF);
    a_access(1, 4'h0, 10'd5, 32'h0);
    check("lat_early_valid", a_valid[1], 0);
    tick();
    check("lat_dout", a_dout[63:32], 32'hDEADBEEF);
    check("lat_valid", a_valid[1], 1);
    check("lat_vaddr", a_vaddr[19:10], 10'd5);

    a_access(0, 4'hF, 10'd3, 32'h11223344);
    a_access(0, 4'b0011, 10'd3, 32'hAABBCCDD);
    tick();
    check("rf_same_port", a_dout[31:0], 32'h11223344);
    a_access(0, 4'h0, 10'd3, 32'h0);
    tick();
    check("rf_reread", a_dout[31:0], 32'h1122CCDD);

    // byte1 goes to port1, uncontested bytes keep port0's 0x000000FF data
    a_idle(); a_drive(0, 4'hF, 10'd7, 32'h000000FF); a_drive(1, 4'b0010, 10'd7, 32'h0000AB00);
    tick(); a_idle(); tick();
`ifdef QU_RAM_COLLISION_FLAG_EN
    check("coll_flag", a_col, 2'b01);
`endif
    a_access(0, 4'h0, 10'd7, 32'h0);
    tick();
    check("coll_merge", a_dout[31:0], 32'h0000ABFF);

    a_access(0, 4'hF, 10'd9, 32'h55);
    tick();
    a_access(0, 4'h0, 10'd9, 32'h0);
    a_regce[0] = 1'b0;
    a_drive(0, 4'hF, 10'd9, 32'h66);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_valid", a_valid[0], 0);
      check("stall_dout", a_dout[31:0], 0);
    end
    a_idle(); a_regce[0] = 1'b1;
    tick();
    check("stall_rel_dout", a_dout[31:0], 32'h55);
    check("stall_rel_vaddr", a_vaddr[9:0], 10'd9);
    check("stall_rel_valid", a_valid[0], 1);
    a_access(0, 4'h0, 10'd9, 32'h0);
    tick();
    check("stall_write", a_dout[31:0], 32'h66);

    a_access(0, 4'h0, 10'd5, 32'h0);
    a_access(0, 4'h0, 10'd7, 32'h0);
    check("pre_rst_dout", a_dout[31:0], 32'hDEADBEEF);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", a_valid[0], 0);
    check("async_rst_dout", a_dout[31:0], 0);
    check("async_rst_vaddr", a_vaddr[9:0], 0);
    #2 rst = 1'b0;
    tick();
    check("rst_flush", a_valid[0], 0);
    a_access(0, 4'h0, 10'd5, 32'h0);
    tick();
    check("rst_mem_kept", a_dout[31:0], 32'hDEADBEEF);

    // WRITE_FIRST (u_b) and NO_CHANGE (u_c) same-port behaviour
    b_access(0, 4'hF, 10'd3, 32'h11223344);
    b_access(0, 4'b0011, 10'd3, 32'hAABBCCDD);
    check("nc_valid", c_valid[0], 0);
    tick(2);
    check("wf_same_port", b_dout[31:0], 32'h1122CCDD);
    check("wf_valid", b_valid[0], 1);
    b_access(0, 4'h0, 10'd3, 32'h0);
    check("nc_reread", c_dout[31:0], 32'h1122CCDD);
    check("nc_reread_valid", c_valid[0], 1);
    tick(2);
    check("wf_reread", b_dout[31:0], 32'h1122CCDD);

    b_idle(); b_drive(0, 4'h0, 10'd3, 32'h0); b_drive(2, 4'hF, 10'd3, 32'h0BADF00D);
    tick(); b_idle();
    check("nc_xport", c_dout[31:0], 32'h1122CCDD);
`ifdef QU_RAM_COLLISION_FLAG_EN
    check("nc_xport_flag", c_col[0], 1);
`endif
    tick(2);
    check("wf_xport", b_dout[31:0], 32'h1122CCDD);
    b_access(1, 4'h0, 10'd3, 32'h0);
    check("xport_after", c_dout[63:32], 32'h0BADF00D);

    b_access(1, 4'hF, 10'd1000, 32'h12345678);
    b_access(1, 4'h0, 10'd1000, 32'h0);
    check("oor_dout", c_dout[63:32], 0);
    check("oor_valid", c_valid[1], 1);
    check("oor_vaddr", c_vaddr[19:10], 10'd1000);
    tick(2);
    check("b_addr1000", b_dout[63:32], 32'h12345678);

    for (int k = 0; k < 4; k++) begin
      b_idle();
      for (int p = 0; p < 4; p++) begin
        ad = 10'(4*k + p);
        b_drive(p, 4'hF, ad, 32'hC0DE0000 | 32'(ad));
      end
      tick();
    end
    b_idle();
    tick(3);

    for (int k = 0; k < 18; k++) begin
      b_idle();
      if (k < 16) begin
        for (int p = 0; p < 4; p++) begin
          ad = 10'((k + p) % 16);
          b_drive(p, 4'h0, ad, 32'h0);
          e[p*32 +: 32] = 32'hC0DE0000 | 32'(ad);
        end
        exp_q.push_back(e);
      end
      tick();
      if (k < 16) begin
        check("b2b_c_valid", c_valid, 4'hF);
        for (int p = 0; p < 4; p++) begin
          ad = 10'((k + p) % 16);
          check("b2b_c_dout", c_dout[p*32 +: 32], 32'hC0DE0000 | 32'(ad));
          check("b2b_c_vaddr", c_vaddr[p*10 +: 10], ad);
        end
      end
      if (k >= 2) begin
        check("b2b_b_valid", b_valid, 4'hF);
        check("b2b_b_dout", b_dout, exp_q.pop_front());
      end else begin
        check("b2b_b_lead", b_valid, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
